regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with an integrated pending-write scoreboard. It replaces the fixed two-read register file in the RISC-V pipeline. ID reads NRD operands combinationally. ID learns whether each operand is still owed by an in-flight long-latency instruction, such as a load or D-cache miss. WB writes one result per cycle and retires the matching scoreboard entry.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREG, 32, number of architectural registers (power of two, ≥ 2)
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREG), register index width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rd_addr  in  NRD*AW  read indices; port i at bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i at bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i's register has a pending write
- wen  in  1  WB write strobe
- waddr  in  AW  WB destination index
- wdata  in  XLEN  WB data
- wclr  in  1  with wen, this write retires the scoreboard entry for waddr
- iss_valid  in  1  ID issues an instruction whose result is tracked
- iss_rd  in  AW  destination of the tracked instruction
- flush  in  1  clear all pending bits (branch mispredict / trap)
- pend_cnt  out  AW+1  number of registers currently pending

## Operation
- Register 0 reads as 0 and is never written. It is never pending, so iss_rd = 0 and waddr = 0 are ignored for both storage and scoreboard.
- Storage: NREG-1 flops of XLEN bits. On a clock edge with wen = 1 and waddr ≠ 0, regs[waddr] ← wdata.
- Reads are combinational from rd_addr.
  - rd_data[i] = regs[rd_addr[i]], subject to the bypass rule in Configuration.
  - rd_busy[i] = pend[rd_addr[i]] & ~(wen & wclr & waddr == rd_addr[i]). A retiring write un-busies the operand in the same cycle.
- Scoreboard: one pending bit per register. Per-edge update, in priority order:
  1. flush = 1 → all bits cleared. A same-cycle iss_valid is also dropped.
  2. Otherwise, clear: wen & wclr & waddr ≠ 0 → pend[waddr] ← 0.
  3. Then set: iss_valid & iss_rd ≠ 0 → pend[iss_rd] ← 1.
- If the clear and the set target the same register, the set wins and the bit ends at 1, because the new producer owns the register.
- wclr without a pending bit is legal and leaves the bit at 0.
- iss_valid to an already-pending register is legal (WAW) and leaves the bit at 1. A single bit is kept, so the first retiring write clears it. ID must stall WAW; this block does not detect it.
- pend_cnt is the popcount of pend, registered: it reflects the state after the current edge. Range 0..NREG-1.
- wen does not depend on flush. The write still commits storage under flush; flush affects only the scoreboard.

## Timing
- Reset (rst = 1 at an edge): all regs = 0, all pend = 0, pend_cnt = 0. rd_data and rd_busy are combinational and therefore 0 for every address during and after reset until written.
- rst takes priority over every other input in that cycle. Reset asserted mid-operation discards pending bits and register contents.
- Read latency is 0 cycles (combinational).
- Write latency: visible at the next cycle's read. With bypass enabled, it is also visible in the same cycle.
- Scoreboard set is visible on rd_busy the cycle after iss_valid. Clear is visible the same cycle, via the retire term.
- No handshakes. All inputs are sampled every edge and there is no backpressure.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If wen = 1, waddr ≠ 0 and rd_addr[i] = waddr, then rd_data[i] = wdata in the same cycle. This is WB→ID write-through forwarding.
- Undefined:
  - rd_data[i] returns the pre-edge stored value. The pipeline must then provide its own WB→ID forwarding or a one-cycle stall.
- rd_busy behaviour is identical in both builds.

## Test plan
- Reset, then read all 32 indices on both ports → rd_data = 0, rd_busy = 0, pend_cnt = 0. Write x0 ← 0xDEADBEEF, then read x0 → 0.
- Write x5 ← 0x12345678 with rd_addr[0] = 5 in the same cycle:
  - With REGFILE_BYPASS_EN → 0x12345678 immediately.
  - Without it → old value 0, then 0x12345678 on the next cycle.
- Issue iss_rd = 7, then read x7 → rd_busy = 1 and pend_cnt = 1. WB wen/wclr to x7 with 0xA5A5A5A5 → rd_busy = 0 that cycle and pend_cnt = 0 on the next cycle.
- Same cycle: wclr to x9 (pending) and iss_valid to x9 → pend[x9] stays 1. Same cycle: wclr x3 and iss x4 → x3 clears, x4 sets, pend_cnt unchanged.
- Issue x1, x2, x3, then assert flush together with iss_valid x4 → pend_cnt = 0 and all rd_busy = 0. x4 is not pending.
- Issue x10 and write x10 ← 0xFFFFFFFF, then pulse rst → x10 reads 0, rd_busy = 0 and pend_cnt = 0. Repeat with NRD = 4, XLEN = 64 and NREG = 16, checking all four ports for the same x10 values.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with a pending-write scoreboard for ID hazard checks.
// Optional WB->ID write-through forwarding is compiled in with `define REGFILE_BYPASS_EN.

// One read port: stored data (or forwarded WB data) plus the operand-busy flag.
module regfile_mp_rd #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]              raddr,
  input  logic [NREG-1:0][XLEN-1:0]  regs,
  input  logic [NREG-1:0]            pend,
  input  logic                       wen,
  input  logic                       wclr,
  input  logic [AW-1:0]              waddr,
  input  logic [XLEN-1:0]            wdata,
  input  logic                       byp_en,
  output logic [XLEN-1:0]            rdata,
  output logic                       busy
);
  logic hit;

  assign hit   = wen && (waddr == raddr);
  assign rdata = (byp_en && hit && (raddr != '0)) ? wdata : regs[raddr];
  // A retiring write frees the operand in the same cycle it lands.
  assign busy  = pend[raddr] && !(hit && wclr);
endmodule

module regfile_mp #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic                wclr,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);
`ifdef REGFILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREG-1:0]           pend_q, pend_d;
  logic [AW:0]               pend_cnt_q, pend_cnt_d;

  always_comb begin
    regs_d = regs_q;
    if (wen && (waddr != '0)) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  // Flush beats everything; otherwise clear then set, so a new producer wins over a retire.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else begin
      if (wen && wclr && (waddr != '0)) pend_d[waddr] = 1'b0;
      if (iss_valid && (iss_rd != '0)) pend_d[iss_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NREG; i++) pend_cnt_d = pend_cnt_d + (AW+1)'(pend_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '0;
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_mp_rd #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rd (
      .raddr  (rd_addr[i*AW +: AW]),
      .regs   (regs_q),
      .pend   (pend_q),
      .wen    (wen),
      .wclr   (wclr),
      .waddr  (waddr),
      .wdata  (wdata),
      .byp_en (BYP),
      .rdata  (rd_data[i*XLEN +: XLEN]),
      .busy   (rd_busy[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus random traffic against an array-based model.
// A second instance (NRD=4, XLEN=64, NREG=16) covers the wide-configuration reset case.
module tb_regfile_mp;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2*AW-1:0] rd_addr;
  logic [63:0]     rd_data;
  logic [1:0]      rd_busy;
  logic            wen, wclr, iss_valid, flush;
  logic [AW-1:0]   waddr, iss_rd;
  logic [31:0]     wdata;
  logic [AW:0]     pend_cnt;

  logic [15:0]     rd_addr2;
  logic [255:0]    rd_data2;
  logic [3:0]      rd_busy2;
  logic            wen2, wclr2, iss_valid2, flush2;
  logic [3:0]      waddr2, iss_rd2;
  logic [63:0]     wdata2;
  logic [4:0]      pend_cnt2;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wclr(wclr), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .flush(flush), .pend_cnt(pend_cnt)
  );

  regfile_mp #(.XLEN(64), .NREG(16), .NRD(4)) dut2 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
    .wen(wen2), .waddr(waddr2), .wdata(wdata2), .wclr(wclr2), .iss_valid(iss_valid2),
    .iss_rd(iss_rd2), .flush(flush2), .pend_cnt(pend_cnt2)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mregs [32];
  bit          mpend [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int mcnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mpend[i]);
    return n;
  endfunction

  task automatic idle();
    wen = 0; wclr = 0; iss_valid = 0; flush = 0; rst = 0;
    waddr = '0; iss_rd = '0; wdata = '0;
    wen2 = 0; wclr2 = 0; iss_valid2 = 0; flush2 = 0;
    waddr2 = '0; iss_rd2 = '0; wdata2 = '0;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  // Combinational outputs against the model's pre-edge state.
  task automatic pre();
    logic [AW-1:0] a;
    logic [31:0]   ed;
    bit            eb;
    #1;
    for (int p = 0; p < 2; p++) begin
      a  = rd_addr[p*AW +: AW];
      ed = mregs[a];
      if (BYP && wen && waddr != 0 && waddr == a) ed = wdata;
      eb = mpend[a] && !(wen && wclr && waddr == a);
      chk($sformatf("rd_data%0d[x%0d]", p, a), 64'(rd_data[p*32 +: 32]), 64'(ed));
      chk($sformatf("rd_busy%0d[x%0d]", p, a), 64'(rd_busy[p]), 64'(eb));
    end
  endtask

  task automatic post();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mregs[i] = '0; mpend[i] = 0; end
    end else begin
      if (wen && waddr != 0) mregs[waddr] = wdata;
      if (flush) begin
        for (int i = 0; i < 32; i++) mpend[i] = 0;
      end else begin
        if (wen && wclr && waddr != 0) mpend[waddr] = 0;
        if (iss_valid && iss_rd != 0) mpend[iss_rd] = 1;
      end
    end
    #1 chk("pend_cnt", 64'(pend_cnt), 64'(mcnt()));
    @(negedge clk);
  endtask

  task automatic cyc();
    pre();
    post();
  endtask

  initial begin
    idle();
    rd(0, 0);
    rd_addr2 = '0;
    for (int i = 0; i < 32; i++) begin mregs[i] = '0; mpend[i] = 0; end

    // Reset
    rst = 1;
    @(posedge clk);
    #1 chk("rst_pend_cnt", 64'(pend_cnt), 64'd0);
    chk("rst_pend_cnt2", 64'(pend_cnt2), 64'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 32; i++) begin rd(i, 31 - i); cyc(); end

    // x0 is never written
    wen = 1; waddr = 0; wdata = 32'hDEADBEEF; rd(0, 0); cyc();
    idle(); pre(); chk("x0_read", 64'(rd_data[31:0]), 64'd0); post();

    // Same-cycle write/read of x5
    wen = 1; waddr = 5; wdata = 32'h12345678; rd(5, 5);
    pre(); chk("x5_same_cycle", 64'(rd_data[31:0]), BYP ? 64'h12345678 : 64'd0); post();
    idle(); pre(); chk("x5_next_cycle", 64'(rd_data[63:32]), 64'h12345678); post();

    // Issue x7, then retire it
    iss_valid = 1; iss_rd = 7; rd(7, 0); cyc();
    idle(); pre(); chk("x7_busy", 64'(rd_busy[0]), 64'd1); post();
    chk("x7_cnt", 64'(pend_cnt), 64'd1);
    wen = 1; wclr = 1; waddr = 7; wdata = 32'hA5A5A5A5;
    pre(); chk("x7_retire_busy", 64'(rd_busy[0]), 64'd0); post();
    chk("x7_cnt_after", 64'(pend_cnt), 64'd0);

    // Retire and reissue the same register: set wins
    idle(); iss_valid = 1; iss_rd = 9; cyc();
    idle(); wen = 1; wclr = 1; waddr = 9; wdata = 32'h99; iss_valid = 1; iss_rd = 9; cyc();
    idle(); rd(9, 9); pre(); chk("x9_still_busy", 64'(rd_busy[1]), 64'd1); post();
    iss_valid = 1; iss_rd = 3; cyc();
    idle(); wen = 1; wclr = 1; waddr = 3; wdata = 32'h33; iss_valid = 1; iss_rd = 4; cyc();
    chk("swap_cnt", 64'(pend_cnt), 64'd2);
    idle(); rd(3, 4); pre(); chk("x3_free", 64'(rd_busy[0]), 64'd0);
    chk("x4_busy", 64'(rd_busy[1]), 64'd1); post();

    // Flush drops pending bits and the same-cycle issue
    for (int r = 1; r <= 3; r++) begin iss_valid = 1; iss_rd = AW'(r); cyc(); end
    flush = 1; iss_valid = 1; iss_rd = 4; cyc();
    chk("flush_cnt", 64'(pend_cnt), 64'd0);
    idle(); rd(4, 1); pre(); chk("flush_x4", 64'(rd_busy[0]), 64'd0);
    chk("flush_x1", 64'(rd_busy[1]), 64'd0); post();

    // Reset mid-operation, both configurations
    iss_valid = 1; iss_rd = 10; iss_valid2 = 1; iss_rd2 = 10; rd(10, 10); cyc();
    idle(); wen = 1; waddr = 10; wdata = 32'hFFFFFFFF;
    wen2 = 1; waddr2 = 10; wdata2 = 64'hFFFF_FFFF_FFFF_FFFF; cyc();
    idle(); rd_addr2 = {4{4'd10}};
    pre();
    chk("w_x10_data", 64'(rd_data[31:0]), 64'hFFFFFFFF);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("w_x10_data_p%0d", p), rd_data2[p*64 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
      chk($sformatf("w_x10_busy_p%0d", p), 64'(rd_busy2[p]), 64'd1);
    end
    post();
    rst = 1; cyc();
    idle(); pre();
    chk("rst_x10_data", 64'(rd_data[31:0]), 64'd0);
    chk("rst_x10_busy", 64'(rd_busy[0]), 64'd0);
    chk("rst_cnt2", 64'(pend_cnt2), 64'd0);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("rst_x10_data_p%0d", p), rd_data2[p*64 +: 64], 64'd0);
      chk($sformatf("rst_x10_busy_p%0d", p), 64'(rd_busy2[p]), 64'd0);
    end
    post();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rd_addr   = (2*AW)'($urandom);
      wen       = ($urandom_range(0, 1) == 1);
      wclr      = ($urandom_range(0, 2) != 0);
      waddr     = AW'($urandom);
      wdata     = $urandom;
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd    = AW'($urandom);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = waddr;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
